// File: rtl/mul_feed_1447.sv
// mul_feed_1447: two-stage operand/product pipeline feeding a 21-bit Barrett reducer.
// Optional operand range check is compiled in with `define MUL_FEED_1447_RANGE_CHECK_EN.
module mul_feed_1447 #(
  parameter int unsigned Q = 1447
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] a_in,
  input  logic [10:0] b_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [20:0] dout_p,
  output logic [15:0] prod_cnt,
  output logic        err_range
);

  localparam int unsigned OP_W   = $clog2(Q);
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned OUT_W  = 21;
  localparam int unsigned CNT_W  = 16;

`ifdef MUL_FEED_1447_RANGE_CHECK_EN
  function automatic logic in_range_f(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    in_range_f = (32'(a) < Q) && (32'(b) < Q);
  endfunction
`endif

  logic              s1_valid_r;
  logic [OP_W-1:0]   s1_a_r;
  logic [OP_W-1:0]   s1_b_r;
  logic              s2_valid_r;
  logic [PROD_W-1:0] s2_prod_r;
  logic [CNT_W-1:0]  prod_cnt_r;

  logic              out_xfer_s;
  logic              s2_adv_s;
  logic              s1_adv_s;
  logic              in_xfer_s;
  logic              keep_s;
  logic              bad_s;
  logic [PROD_W-1:0] prod_s;
  logic              prod_hi_unused_s;

  // Handshake: a stage advances when it is empty or its successor moves on.
  always_comb begin
    out_xfer_s = s2_valid_r & out_ready;
    s2_adv_s   = (~s2_valid_r) | out_xfer_s;
    s1_adv_s   = (~s1_valid_r) | s2_adv_s;
    in_xfer_s  = in_valid & s1_adv_s;
  end

  assign in_ready = s1_adv_s;

`ifdef MUL_FEED_1447_RANGE_CHECK_EN
  // Out-of-range pairs are still accepted, but never reach S1.
  always_comb begin
    keep_s = 1'b1;
    bad_s  = 1'b0;
    if (in_range_f(a_in, b_in)) begin
      keep_s = 1'b1;
      bad_s  = 1'b0;
    end else begin
      keep_s = 1'b0;
      bad_s  = in_xfer_s;
    end
  end
`else
  assign keep_s = 1'b1;
  assign bad_s  = 1'b0;
`endif

  // Full-width product of the S1 operands.
  always_comb begin
    prod_s = PROD_W'(s1_a_r) * PROD_W'(s1_b_r);
  end

  // S1: operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {OP_W{1'b0}};
      s1_b_r     <= {OP_W{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= in_xfer_s & keep_s;
      s1_a_r     <= a_in;
      s1_b_r     <= b_in;
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_a_r     <= s1_a_r;
      s1_b_r     <= s1_b_r;
    end
  end

  // S2: product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_prod_r  <= {PROD_W{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_prod_r  <= prod_s;
    end else begin
      s2_valid_r <= s2_valid_r;
      s2_prod_r  <= s2_prod_r;
    end
  end

  // Count of products handed downstream; wraps naturally at 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_cnt_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s) begin
      prod_cnt_r <= prod_cnt_r + 16'd1;
    end else begin
      prod_cnt_r <= prod_cnt_r;
    end
  end

`ifdef MUL_FEED_1447_RANGE_CHECK_EN
  logic err_range_r;

  // Sticky range error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_range_r <= 1'b0;
    end else if (bad_s) begin
      err_range_r <= 1'b1;
    end else begin
      err_range_r <= err_range_r;
    end
  end

  assign err_range = err_range_r;
`else
  assign err_range = 1'b0;
`endif

  // Bit 21 is zero for in-range operands and is intentionally not forwarded.
  assign prod_hi_unused_s = s2_prod_r[PROD_W-1];

  assign out_valid = s2_valid_r;
  assign dout_p    = s2_prod_r[OUT_W-1:0];
  assign prod_cnt  = prod_cnt_r;

endmodule
